// File: rtl/weight_loader_pkg.sv
// -----------------------------------------------------------------------------
// weight_loader_pkg
// Shared definitions for the weight loader: FSM state encoding, the load_err
// code values and a small helper used by the FSM.
//
// Contents:
//   state_t       - FSM state (IDLE=0, LOAD=1, DONE=2, ERR=3)
//   err_t         - 2-bit load error code
//   ERR_NONE      - 2'b00, no error
//   ERR_SHORT     - 2'b01, tlast arrived before the image was complete
//   ERR_LONG      - 2'b10, image filled without tlast on its final word
//   can_start()   - 1 for the states in which start is honoured
// -----------------------------------------------------------------------------
package weight_loader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  typedef logic [1:0] err_t;

  localparam err_t ERR_NONE  = 2'b00;
  localparam err_t ERR_SHORT = 2'b01;
  localparam err_t ERR_LONG  = 2'b10;

  // start is only sampled while no load is in progress.
  function automatic logic can_start(input state_t s);
    return (s == IDLE) || (s == DONE) || (s == ERR);
  endfunction

endpackage

// File: rtl/weight_loader.sv
// -----------------------------------------------------------------------------
// weight_loader
// Streams one weight image from an AXI-Stream style input into NUM_BANKS
// interleaved weight banks. Beat k goes to bank (k mod NUM_BANKS) at word
// address (k / NUM_BANKS). The image must be exactly WEIGHT_LIMIT words with
// tlast on the final word; a short or long image ends in ERR.
//
// Parameters:
//   DATA_W       - stream / weight word width
//   ADDR_W       - per-bank write address width
//   WEIGHT_LIMIT - words per load image (>= 1)
//   NUM_BANKS    - number of weight banks, power of two in 1..16
//   AUTO_START   - 1: enter LOAD straight out of reset, 0: wait in IDLE
//
// Ports:
//   clk            in   single clock
//   rst            in   synchronous active-high reset
//   start          in   request a new load (honoured in IDLE/DONE/ERR only)
//   s_axis_tdata   in   weight word
//   s_axis_tvalid  in   beat valid
//   s_axis_tready  out  high exactly while in LOAD
//   s_axis_tlast   in   last beat of the image
//   weight_wr_data out  registered write data
//   weight_wr_addr out  registered word address within the selected bank
//   weight_wr_en   out  registered one-hot bank write strobe
//   word_count     out  beats accepted in the current load (saturating)
//   load_done      out  level, image loaded correctly
//   load_err       out  level, 01 short image, 10 long image, 00 none
//
// Handshake: a beat transfers on a rising clk edge where s_axis_tvalid and
// s_axis_tready are both 1. tready comes straight from the state register, so
// it never depends on tvalid; upstream must hold tdata/tlast stable while
// tvalid is high and tready is low (beats are never dropped in DONE/ERR).
// -----------------------------------------------------------------------------
module weight_loader
  import weight_loader_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int WEIGHT_LIMIT = 99678,
  parameter int NUM_BANKS    = 4,
  parameter bit AUTO_START   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATA_W-1:0]    s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 s_axis_tlast,
  output logic [DATA_W-1:0]    weight_wr_data,
  output logic [ADDR_W-1:0]    weight_wr_addr,
  output logic [NUM_BANKS-1:0] weight_wr_en,
  output logic [31:0]          word_count,
  output logic                 load_done,
  output logic [1:0]           load_err
);

  // Number of low count bits that select the bank. With a single bank the
  // select field is empty, so the slice width is clamped to 1 and the decode
  // below is special-cased.
  localparam int BANK_SHIFT = $clog2(NUM_BANKS);
  localparam int BANK_W     = (NUM_BANKS > 1) ? BANK_SHIFT : 1;

  localparam logic [31:0] LIMIT    = 32'(WEIGHT_LIMIT);
  localparam logic [31:0] LAST_IDX = 32'(WEIGHT_LIMIT - 1);

  state_t state;

  // The index of the beat currently on the bus equals the number of beats
  // already accepted, so word_count doubles as the beat index k.
  logic                 last_word;
  logic [31:0]          bank_addr;
  logic [NUM_BANKS-1:0] bank_onehot;

  assign last_word = (word_count == LAST_IDX);

  // k / NUM_BANKS: NUM_BANKS is a power of two, so this is a plain shift.
  assign bank_addr = word_count >> BANK_SHIFT;

  // k mod NUM_BANKS: the low BANK_SHIFT bits of the count, decoded one-hot.
  if (NUM_BANKS == 1) begin : g_one_bank
    assign bank_onehot = 1'b1;
  end else begin : g_multi_bank
    always_comb begin
      bank_onehot = '0;
      bank_onehot[word_count[BANK_W-1:0]] = 1'b1;
    end
  end

  // Only the state register feeds tready; no path from tvalid.
  assign s_axis_tready = (state == LOAD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= AUTO_START ? LOAD : IDLE;
      word_count     <= '0;
      weight_wr_en   <= '0;
      weight_wr_data <= '0;
      weight_wr_addr <= '0;
      load_done      <= 1'b0;
      load_err       <= ERR_NONE;
    end else begin
      // Strobe is a single-cycle pulse; data/addr hold between writes.
      weight_wr_en <= '0;

      case (state)
        IDLE, DONE, ERR: begin
          if (can_start(state) && start) begin
            state      <= LOAD;
            word_count <= '0;
            load_done  <= 1'b0;
            load_err   <= ERR_NONE;
          end
        end

        LOAD: begin
          // tvalid low simply stalls: nothing below changes.
          if (s_axis_tvalid) begin
            weight_wr_en   <= bank_onehot;
            weight_wr_data <= s_axis_tdata;
            weight_wr_addr <= ADDR_W'(bank_addr);

            if (word_count != LIMIT) begin
              word_count <= word_count + 32'd1;
            end

            if (last_word) begin
              // Final word of the image: tlast decides good vs. long image.
              if (s_axis_tlast) begin
                state     <= DONE;
                load_done <= 1'b1;
              end else begin
                state    <= ERR;
                load_err <= ERR_LONG;
              end
            end else if (s_axis_tlast) begin
              state    <= ERR;
              load_err <= ERR_SHORT;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_loader.sv
// -----------------------------------------------------------------------------
// tb_weight_loader
// Directed bench for weight_loader (WEIGHT_LIMIT=8, NUM_BANKS=4, AUTO_START=0)
// plus a second instance with AUTO_START=1 for the post-reset tready check.
// A behavioural model (accepted-beat count, loading/done/err flags, k%4, k/4)
// is compared against every output on every falling edge; a write-trace
// queue of hand-computed {en, addr, data} records is checked on each write.
// -----------------------------------------------------------------------------
module tb_weight_loader;

  localparam int          DW    = 32;
  localparam int          AW    = 32;
  localparam int          LIM   = 8;
  localparam int          NB    = 4;
  localparam logic [31:0] LIM32 = 32'd8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start;
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tlast;
  logic          tready;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] wr_addr;
  logic [NB-1:0] wr_en;
  logic [31:0]   word_count;
  logic          load_done;
  logic [1:0]    load_err;

  logic          rst_a;
  logic          start_a  = 1'b0;
  logic [DW-1:0] tdata_a  = '0;
  logic          tvalid_a = 1'b0;
  logic          tlast_a  = 1'b0;
  logic          tready_a;
  logic [DW-1:0] wr_data_a;
  logic [AW-1:0] wr_addr_a;
  logic [NB-1:0] wr_en_a;
  logic [31:0]   word_count_a;
  logic          load_done_a;
  logic [1:0]    load_err_a;

  weight_loader #(
    .DATA_W(DW), .ADDR_W(AW), .WEIGHT_LIMIT(LIM), .NUM_BANKS(NB), .AUTO_START(1'b0)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready),
    .s_axis_tlast(tlast),
    .weight_wr_data(wr_data), .weight_wr_addr(wr_addr), .weight_wr_en(wr_en),
    .word_count(word_count), .load_done(load_done), .load_err(load_err)
  );

  weight_loader #(
    .DATA_W(DW), .ADDR_W(AW), .WEIGHT_LIMIT(LIM), .NUM_BANKS(NB), .AUTO_START(1'b1)
  ) u_dut_auto (
    .clk(clk), .rst(rst_a), .start(start_a),
    .s_axis_tdata(tdata_a), .s_axis_tvalid(tvalid_a), .s_axis_tready(tready_a),
    .s_axis_tlast(tlast_a),
    .weight_wr_data(wr_data_a), .weight_wr_addr(wr_addr_a), .weight_wr_en(wr_en_a),
    .word_count(word_count_a), .load_done(load_done_a), .load_err(load_err_a)
  );

  // ---------------- scoreboard ----------------
  int          n_vec = 0;
  int          n_err = 0;
  bit          cmp_en = 1'b0;
  logic [67:0] exp_q[$];

  task automatic chk(input string nm, input logic [67:0] act, input logic [67:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected write record for beat k: one-hot bank k%4, address k/4.
  task automatic push_wr(input int k, input logic [31:0] d);
    exp_q.push_back({4'(1 << (k % NB)), 32'(k / NB), d});
  endtask

  // ---------------- behavioural model ----------------
  // Tracks what the spec says: a load is either in progress or not; each
  // accepted beat is written one cycle later; the image ends at LIM words or
  // at tlast, whichever decides first.
  logic        m_loading, m_done, m_wr;
  logic [1:0]  m_err;
  logic [31:0] m_count, m_addr, m_data;
  logic [3:0]  m_en;

  always @(posedge clk) begin
    if (rst) begin
      m_loading <= 1'b0;
      m_done    <= 1'b0;
      m_err     <= 2'b00;
      m_count   <= '0;
      m_wr      <= 1'b0;
      m_en      <= '0;
      m_addr    <= '0;
      m_data    <= '0;
    end else begin
      m_wr <= 1'b0;
      if (!m_loading) begin
        if (start) begin
          m_loading <= 1'b1;
          m_count   <= '0;
          m_done    <= 1'b0;
          m_err     <= 2'b00;
        end
      end else if (tvalid) begin
        m_wr    <= 1'b1;
        m_en    <= 4'(1 << (m_count % NB));
        m_addr  <= m_count / NB;
        m_data  <= tdata;
        m_count <= (m_count < LIM32) ? m_count + 32'd1 : m_count;
        if (m_count + 32'd1 == LIM32) begin
          m_loading <= 1'b0;
          if (tlast) m_done <= 1'b1;
          else       m_err  <= 2'b10;
        end else if (tlast) begin
          m_loading <= 1'b0;
          m_err     <= 2'b01;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Present one beat and hold it until it transfers (bounded).
  task automatic send_beat(input logic [31:0] d, input logic l);
    int t;
    t = 0;
    tvalid = 1'b1;
    tdata  = d;
    tlast  = l;
    while (!tready && t < 50) begin
      step();
      t++;
    end
    if (t >= 50) begin
      n_vec++;
      n_err++;
      $display("FAIL beat_timeout: tready=%0b, required 1 within 50 cycles", tready);
    end
    step();
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic gap(input int n);
    tvalid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [67:0] item;
    rst = 1'b1; rst_a = 1'b1; start = 1'b0;
    tvalid = 1'b0; tlast = 1'b0; tdata = '0;

    // Per-cycle compare and write-trace monitor.
    fork
      forever begin
        @(negedge clk);
        if (cmp_en) begin
          chk("tready",     tready,     m_loading);
          chk("word_count", word_count, m_count);
          chk("load_done",  load_done,  m_done);
          chk("load_err",   load_err,   m_err);
          chk("wr_en",      wr_en,      m_wr ? m_en : 4'b0000);
          chk("wr_data",    wr_data,    m_data);
          chk("wr_addr",    wr_addr,    m_addr);
          if (wr_en !== 4'b0000) begin
            if (exp_q.size() == 0) begin
              n_vec++;
              n_err++;
              $display("FAIL wr_trace: got write en=%0h addr=%0h data=%0h, required none",
                       wr_en, wr_addr, wr_data);
            end else begin
              item = exp_q.pop_front();
              chk("wr_trace", {wr_en, wr_addr, wr_data}, item);
            end
          end
        end
      end
    join_none

    step();
    cmp_en = 1'b1;
    step();

    // Reset state, literal.
    chk("rst_tready",  tready,     1'b0);
    chk("rst_wr_en",   wr_en,      4'b0000);
    chk("rst_count",   word_count, 32'd0);
    chk("rst_err",     load_err,   2'b00);
    chk("auto_rst_tready", tready_a, 1'b1);
    rst = 1'b0;
    rst_a = 1'b0;
    step();
    chk("auto_rel_tready", tready_a, 1'b1);
    chk("auto_rel_count",  word_count_a, 32'd0);
    gap(2);

    // Nominal: 8 back-to-back beats, tlast on beat 7.
    do_start();
    for (int i = 0; i < LIM; i++) begin
      push_wr(i, 32'hA0 + 32'(i));
      send_beat(32'hA0 + 32'(i), i == LIM - 1);
    end
    chk("nom_wr_en",   wr_en,      4'b1000);
    chk("nom_wr_addr", wr_addr,    32'd1);
    chk("nom_wr_data", wr_data,    32'hA7);
    chk("nom_count",   word_count, 32'd8);
    chk("nom_done",    load_done,  1'b1);
    chk("nom_tready",  tready,     1'b0);
    gap(2);
    chk("nom_q_empty", 32'(exp_q.size()), 32'd0);
    chk("nom_hold_data", wr_data, 32'hA7);

    // Short: 5 beats, tlast on beat 4.
    do_start();
    for (int i = 0; i < 5; i++) begin
      push_wr(i, 32'h50 + 32'(i));
      send_beat(32'h50 + 32'(i), i == 4);
    end
    chk("short_err",    load_err,   2'b01);
    chk("short_tready", tready,     1'b0);
    chk("short_count",  word_count, 32'd5);
    chk("short_done",   load_done,  1'b0);
    gap(2);
    chk("short_q_empty", 32'(exp_q.size()), 32'd0);

    // Long: 8 beats without tlast, then a 9th held on the bus.
    do_start();
    for (int i = 0; i < LIM; i++) begin
      push_wr(i, 32'h70 + 32'(i));
      send_beat(32'h70 + 32'(i), 1'b0);
    end
    tvalid = 1'b1;
    tdata  = 32'h99;
    tlast  = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("long_err",    load_err,   2'b10);
    chk("long_tready", tready,     1'b0);
    chk("long_count",  word_count, 32'd8);
    tvalid = 1'b0;
    gap(1);
    chk("long_q_empty", 32'(exp_q.size()), 32'd0);

    // Stall: same image as nominal with random tvalid gaps.
    do_start();
    for (int i = 0; i < LIM; i++) begin
      gap($urandom_range(0, 3));
      push_wr(i, 32'hA0 + 32'(i));
      send_beat(32'hA0 + 32'(i), i == LIM - 1);
    end
    chk("stall_done",  load_done,  1'b1);
    chk("stall_count", word_count, 32'd8);
    gap(1);

    // Reload after DONE: count restarts, bank0 addr0 rewritten.
    do_start();
    chk("reload_count", word_count, 32'd0);
    chk("reload_done",  load_done,  1'b0);
    push_wr(0, 32'hB0);
    send_beat(32'hB0, 1'b0);
    chk("reload_wr",    {wr_en, wr_addr, wr_data}, {4'b0001, 32'd0, 32'hB0});
    chk("reload_count1", word_count, 32'd1);

    // start is ignored while loading.
    start = 1'b1;
    step();
    start = 1'b0;
    chk("ign_start_count",  word_count, 32'd1);
    chk("ign_start_tready", tready,     1'b1);

    // Reset mid-load: beats 1 and 2 land, beat 3 is on the bus when rst hits.
    push_wr(1, 32'hC1);
    send_beat(32'hC1, 1'b0);
    push_wr(2, 32'hC2);
    send_beat(32'hC2, 1'b0);
    tvalid = 1'b1;
    tdata  = 32'hC3;
    rst    = 1'b1;
    step();
    chk("mid_rst_wr_en",  wr_en,      4'b0000);
    chk("mid_rst_data",   wr_data,    32'd0);
    chk("mid_rst_addr",   wr_addr,    32'd0);
    chk("mid_rst_count",  word_count, 32'd0);
    chk("mid_rst_flags",  {load_done, load_err}, 3'b000);
    rst    = 1'b0;
    tvalid = 1'b0;
    step();
    chk("mid_rst_tready", tready, 1'b0);
    gap(2);
    chk("mid_rst_q_empty", 32'(exp_q.size()), 32'd0);

    // AUTO_START=1: tready one cycle after release.
    rst_a = 1'b1;
    step();
    step();
    rst_a = 1'b0;
    step();
    chk("auto_tready",  tready_a,     1'b1);
    chk("auto_wr_en",   wr_en_a,      4'b0000);
    chk("auto_flags",   {load_done_a, load_err_a}, 3'b000);

    gap(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
